// File: rtl/sobel_line_buffer_pkg.sv
// Shared types and constants for the Sobel 3-row line buffer.
package sobel_line_buffer_pkg;

  localparam int unsigned PIXEL_W    = 8;
  localparam int unsigned PRIME_ROWS = 2;
  localparam int unsigned WORD_W     = 2 * PIXEL_W;

  typedef logic [PIXEL_W-1:0] pixel_t;

  // One line-RAM word: the two rows above the current pixel in the same column.
  typedef struct packed {
    pixel_t row_n1;
    pixel_t row_n2;
  } line_word_t;

  // Shift a column down by one row: the new pixel becomes row n-1, old row n-1 becomes n-2.
  function automatic line_word_t shift_word(input pixel_t pix, input line_word_t old);
    line_word_t w;
    w.row_n1 = pix;
    w.row_n2 = old.row_n1;
    return w;
  endfunction

endpackage

// File: rtl/sobel_line_ram.sv
// Column-indexed line store: one synchronous read port with enable, one write port.
module sobel_line_ram
  import sobel_line_buffer_pkg::*;
#(
  parameter int DEPTH  = 512,
  parameter int ADDR_W = 9,
  parameter int DATA_W = WORD_W
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  // No reset so the array maps onto block RAM.
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/sobel_line_buffer.sv
// Raster-to-column converter: emits a vertical 3-pixel column per accepted pixel once
// two full rows of the current frame have been stored.
module sobel_line_buffer
  import sobel_line_buffer_pkg::*;
#(
  parameter int LINE_WIDTH = 512,
  parameter int ADDR_W     = 9
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [PIXEL_W-1:0] i_pixel,
  input  logic               i_sof,
  input  logic               i_pixel_valid,
  output logic               o_pixel_ack,
  output logic [PIXEL_W-1:0] o_pixel_1,
  output logic [PIXEL_W-1:0] o_pixel_2,
  output logic [PIXEL_W-1:0] o_pixel_3,
  output logic               o_pixel_valid,
  input  logic               i_pixel_ack
);

  logic              w_advance;
  logic              w_accept;
  logic [ADDR_W-1:0] w_cur_col;
  logic [1:0]        w_cur_row;
  logic              w_last_col;

  logic [ADDR_W-1:0] r_col;
  logic [1:0]        r_row;

  logic              r_s1_valid;
  logic              r_s1_primed;
  pixel_t            r_s1_pix;
  logic [ADDR_W-1:0] r_s1_col;

  logic              r_fwd;
  line_word_t        r_fwd_word;
  line_word_t        w_ram_word;
  line_word_t        w_rd_word;
  logic              w_wr_en;
  line_word_t        w_wr_word;

  logic              r_out_valid;
  pixel_t            r_out_1;
  pixel_t            r_out_2;
  pixel_t            r_out_3;

  assign w_advance   = ~r_out_valid | i_pixel_ack;
  assign w_accept    = i_pixel_valid & w_advance;
  assign o_pixel_ack = w_advance;

  // Start-of-frame overrides whatever position the counters hold.
  assign w_cur_col  = i_sof ? '0 : r_col;
  assign w_cur_row  = i_sof ? 2'd0 : r_row;
  assign w_last_col = (w_cur_col == ADDR_W'(LINE_WIDTH - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_col <= '0;
      r_row <= 2'd0;
    end else if (w_accept) begin
      r_col <= w_last_col ? '0 : w_cur_col + 1'b1;
      if (w_last_col && (w_cur_row < 2'(PRIME_ROWS))) r_row <= w_cur_row + 2'd1;
      else                                            r_row <= w_cur_row;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1_valid  <= 1'b0;
      r_s1_primed <= 1'b0;
      r_s1_pix    <= '0;
      r_s1_col    <= '0;
    end else if (w_advance) begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_pix    <= i_pixel;
        r_s1_col    <= w_cur_col;
        r_s1_primed <= (w_cur_row == 2'(PRIME_ROWS));
      end
    end
  end

  assign w_wr_en   = w_advance & r_s1_valid;
  assign w_wr_word = shift_word(r_s1_pix, w_rd_word);

  sobel_line_ram #(
    .DEPTH  (LINE_WIDTH),
    .ADDR_W (ADDR_W),
    .DATA_W (WORD_W)
  ) u_ram (
    .i_clk   (i_clk),
    .i_we    (w_wr_en),
    .i_waddr (r_s1_col),
    .i_wdata (w_wr_word),
    .i_re    (w_advance),
    .i_raddr (w_cur_col),
    .o_rdata (w_ram_word)
  );

  // A read hitting the column being written this cycle (back-to-back sof at column 0)
  // would see stale RAM data, so the written word is forwarded instead.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_fwd      <= 1'b0;
      r_fwd_word <= '0;
    end else if (w_advance) begin
      r_fwd      <= w_wr_en && (r_s1_col == w_cur_col);
      r_fwd_word <= w_wr_word;
    end
  end

  assign w_rd_word = r_fwd ? r_fwd_word : w_ram_word;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_out_valid <= 1'b0;
      r_out_1     <= '0;
      r_out_2     <= '0;
      r_out_3     <= '0;
    end else if (w_advance) begin
      r_out_valid <= r_s1_valid & r_s1_primed;
      if (r_s1_valid && r_s1_primed) begin
        r_out_1 <= w_rd_word.row_n2;
        r_out_2 <= w_rd_word.row_n1;
        r_out_3 <= r_s1_pix;
      end
    end
  end

  assign o_pixel_valid = r_out_valid;
  assign o_pixel_1     = r_out_1;
  assign o_pixel_2     = r_out_2;
  assign o_pixel_3     = r_out_3;

endmodule

// File: tb/tb_sobel_line_buffer.sv
// Scoreboard bench for sobel_line_buffer with a 4-pixel line.
module tb_sobel_line_buffer;

  localparam int LW = 4;
  localparam int AW = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] i_pixel;
  logic       i_sof;
  logic       i_pixel_valid;
  logic       o_pixel_ack;
  logic [7:0] o_pixel_1;
  logic [7:0] o_pixel_2;
  logic [7:0] o_pixel_3;
  logic       o_pixel_valid;
  logic       i_pixel_ack;

  sobel_line_buffer #(
    .LINE_WIDTH (LW),
    .ADDR_W     (AW)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_pixel       (i_pixel),
    .i_sof         (i_sof),
    .i_pixel_valid (i_pixel_valid),
    .o_pixel_ack   (o_pixel_ack),
    .o_pixel_1     (o_pixel_1),
    .o_pixel_2     (o_pixel_2),
    .o_pixel_3     (o_pixel_3),
    .o_pixel_valid (o_pixel_valid),
    .i_pixel_ack   (i_pixel_ack)
  );

  always #5 clk = ~clk;

  typedef logic [23:0] col_t;

  col_t       exp_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  int         n_out    = 0;
  logic [7:0] m_top[LW];
  logic [7:0] m_mid[LW];
  int         m_col;
  int         m_row;
  logic       mark_first = 1'b0;
  col_t       first_out;
  time        t_first;
  logic       rand_ack = 1'b0;
  logic       rand_gap = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_col = 0;
    m_row = 0;
    exp_q.delete();
  endtask

  // Golden model: two stored rows per column, output once two rows of the frame are seen.
  task automatic model_accept(input logic [7:0] pix, input logic sof);
    if (sof) begin
      m_col = 0;
      m_row = 0;
    end
    if (m_row == 2) exp_q.push_back({m_top[m_col], m_mid[m_col], pix});
    m_top[m_col] = m_mid[m_col];
    m_mid[m_col] = pix;
    if (m_col == LW - 1) begin
      m_col = 0;
      if (m_row < 2) m_row++;
    end else begin
      m_col++;
    end
  endtask

  task automatic send(input logic [7:0] pix, input logic sof, output time t_a);
    logic acc;
    acc = 1'b0;
    t_a = 0;
    for (int g = 0; g < 200 && !acc; g++) begin
      @(negedge clk);
      i_pixel_ack = rand_ack ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rand_gap && $urandom_range(0, 2) == 0) begin
        i_pixel_valid = 1'b0;
      end else begin
        i_pixel_valid = 1'b1;
        i_pixel       = pix;
        i_sof         = sof;
      end
      t_a = $time;
      #1;
      acc = i_pixel_valid && o_pixel_ack;
      @(posedge clk);
      if (acc) model_accept(pix, sof);
    end
    if (!acc) begin
      $display("FAIL send_timeout: pixel %h not accepted, required acceptance within 200 cycles",
               pix);
      $fatal(1, "input stalled");
    end
  endtask

  task automatic send_row(input int base, input int r, input logic sof_first,
                          output time t_first_acc);
    time t;
    for (int c = 0; c < LW; c++) begin
      send(8'(base + r * 16 + c), sof_first && (c == 0), t);
      if (c == 0) t_first_acc = t;
    end
  endtask

  task automatic drain(input int n);
    repeat (n) begin
      @(negedge clk);
      i_pixel_valid = 1'b0;
      i_sof         = 1'b0;
      i_pixel_ack   = 1'b1;
    end
  endtask

  // Monitor: an output transfer happens at the next rising edge when valid & ack.
  initial begin : monitor
    col_t got;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && o_pixel_valid && i_pixel_ack) begin
        got = {o_pixel_1, o_pixel_2, o_pixel_3};
        n_out++;
        if (mark_first) begin
          first_out  = got;
          t_first    = $time - 2;
          mark_first = 1'b0;
        end
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_column: got %h expected no output", got);
        end else begin
          check("column", 32'(got), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin : driver
    time t_acc8;
    time t_dummy;
    int  base_out;

    rst_n         = 1'b0;
    i_pixel       = '0;
    i_sof         = 1'b0;
    i_pixel_valid = 1'b0;
    i_pixel_ack   = 1'b1;
    model_reset();
    #1;
    check("reset_valid", 32'(o_pixel_valid), 32'd0);
    check("reset_ack", 32'(o_pixel_ack), 32'd1);
    check("reset_pixels", 32'({o_pixel_1, o_pixel_2, o_pixel_3}), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Rows 0..2: first column two cycles after pixel 8 is accepted.
    send_row(0, 0, 1'b0, t_dummy);
    send_row(0, 1, 1'b0, t_dummy);
    mark_first = 1'b1;
    send_row(0, 2, 1'b0, t_acc8);
    drain(4);
    check("prime_count", 32'(n_out), 32'd4);
    check("first_column", 32'(first_out), 32'h001020);
    check("latency", 32'(t_first - t_acc8), 32'd20);

    // Row 3 with a 5-cycle output stall after column 1.
    send(8'h30, 1'b0, t_dummy);
    send(8'h31, 1'b0, t_dummy);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      i_pixel_ack   = 1'b0;
      i_pixel_valid = 1'b1;
      i_pixel       = 8'h32;
      i_sof         = 1'b0;
      #1;
      check("stall_ack", 32'(o_pixel_ack), 32'd0);
      check("stall_valid", 32'(o_pixel_valid), 32'd1);
      check("stall_hold", 32'({o_pixel_1, o_pixel_2, o_pixel_3}), 32'h102030);
    end
    send(8'h32, 1'b0, t_dummy);
    send(8'h33, 1'b0, t_dummy);
    drain(4);
    check("row3_count", 32'(n_out), 32'd8);

    // Reset while a column is being presented.
    send(8'h40, 1'b0, t_dummy);
    send(8'h41, 1'b0, t_dummy);
    @(negedge clk);
    rst_n         = 1'b0;
    i_pixel_valid = 1'b0;
    #1;
    check("midreset_valid", 32'(o_pixel_valid), 32'd0);
    check("midreset_ack", 32'(o_pixel_ack), 32'd1);
    check("midreset_pixels", 32'({o_pixel_1, o_pixel_2, o_pixel_3}), 32'd0);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Priming restarts after reset; then sof at column 2 of row 3.
    base_out = n_out;
    send_row(0, 0, 1'b0, t_dummy);
    send_row(0, 1, 1'b0, t_dummy);
    send_row(0, 2, 1'b0, t_dummy);
    send(8'h30, 1'b0, t_dummy);
    send(8'h31, 1'b0, t_dummy);
    send_row(8'h80, 0, 1'b1, t_dummy);
    send_row(8'h80, 1, 1'b0, t_dummy);
    check("sof_silent", 32'(n_out - base_out), 32'd6);
    mark_first = 1'b1;
    send_row(8'h80, 2, 1'b0, t_dummy);
    drain(4);
    check("sof_count", 32'(n_out - base_out), 32'd10);
    check("sof_first_column", 32'(first_out), 32'h8090A0);

    // Six rows with random input gaps and output stalls.
    base_out = n_out;
    rand_ack = 1'b1;
    rand_gap = 1'b1;
    for (int r = 0; r < 6; r++) send_row(8'h07, r, r == 0, t_dummy);
    rand_ack = 1'b0;
    rand_gap = 1'b0;
    drain(10);
    check("random_count", 32'(n_out - base_out), 32'd16);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sobel_line_buffer.md
SOBEL_LINE_BUFFER -- requirements
Module: sobel_line_buffer

Interface
REQ-001 SHALL have parameter LINE_WIDTH, default 512, meaning pixels per image line (legal range 4..4096).
REQ-002 SHALL have parameter ADDR_W, default 9, meaning column address width (clog2(LINE_WIDTH)).
REQ-003 SHALL have port i_clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port i_rst_n  input  1  reset; asynchronous assert, active-low.
REQ-005 SHALL have port i_pixel  input  8  raster-order input pixel.
REQ-006 SHALL have port i_sof  input  1  marks i_pixel as the first pixel of a frame; qualified by acceptance.
REQ-007 SHALL have port i_pixel_valid  input  1  input pixel present.
REQ-008 SHALL have port o_pixel_ack  output  1  block can accept the input pixel this cycle.
REQ-009 SHALL have ports o_pixel_1, o_pixel_2, o_pixel_3  output  8 each  vertical column: row n-2 (top), row n-1, row n (bottom).
REQ-010 SHALL have port o_pixel_valid  output  1  output column present.
REQ-011 SHALL have port i_pixel_ack  input  1  downstream accepts the output column.

Function
REQ-012 Accept SHALL occur when i_pixel_valid & o_pixel_ack; advance SHALL be defined as ~o_pixel_valid | i_pixel_ack.
REQ-013 o_pixel_ack SHALL equal advance (combinational); the pipeline SHALL freeze completely when advance is 0.
REQ-014 Column counter SHALL increment per accept and wrap LINE_WIDTH-1 -> 0; on wrap, row counter SHALL increment, saturating at 2.
REQ-015 Accept with i_sof=1 SHALL treat that pixel as column 0, row 0, and counters continue from there; this overrides any mid-line position.
REQ-016 Line RAM SHALL store per column a 16-bit word {row n-1, row n-2}; at accept, the word at the current column SHALL be read (read enable = advance).
REQ-017 Stage 1 (one cycle after accept) SHALL hold pixel, column, and primed flag (row counter == 2 at accept); on advance it SHALL write {pixel, old row n-1} back to the same column.
REQ-018 On advance with stage 1 valid and primed, outputs SHALL load o_pixel_1 = old row n-2, o_pixel_2 = old row n-1, o_pixel_3 = pixel; o_pixel_valid = 1.
REQ-019 Stage 1 valid but not primed SHALL update RAM only; no output.
REQ-020 On advance with no primed stage-1 data, o_pixel_valid SHALL clear.
REQ-021 Latency SHALL be 2 cycles from accept to o_pixel_valid with no backpressure; throughput SHALL be 1 pixel/cycle.
REQ-022 Under backpressure (o_pixel_valid=1, i_pixel_ack=0), outputs, stage 1, and RAM read data SHALL hold stable; no pixel SHALL be lost or duplicated.
REQ-023 The first two rows after reset or i_sof SHALL produce no output; each later row SHALL produce exactly LINE_WIDTH columns.
REQ-024 Uninitialised RAM contents SHALL never reach the outputs.

Reset
REQ-025 On i_rst_n low, o_pixel_valid, stage-1 valid, column, and row counters SHALL clear to 0 immediately; o_pixel_1..3 SHALL reset to 0.
REQ-026 o_pixel_ack SHALL read 1 during and after reset; the RAM array SHALL NOT be reset.
REQ-027 Reset mid-line SHALL discard in-flight data; the next accepted pixel SHALL be column 0, row 0.

Structure
REQ-028 A shared package SHALL hold PIXEL_W = 8 and the row-priming constant PRIME_ROWS = 2.
REQ-029 Storage SHALL be one sub-module, sobel_line_ram: LINE_WIDTH x 16, one synchronous read port with enable, one write port; it SHALL infer block RAM.

Verification
REQ-030 Reset: assert i_rst_n=0 mid-stream -> o_pixel_valid=0 and o_pixel_ack=1 at once; the next pixels restart priming.
REQ-031 LINE_WIDTH=4, rows 0..2 streamed as values row*16+col, i_pixel_ack=1 -> first output (0x00,0x10,0x20) 2 cycles after pixel 8 is accepted; 4 outputs total.
REQ-032 Row 3 streamed after REQ-031 -> outputs (0x10,0x20,0x30)..(0x13,0x23,0x33).
REQ-033 i_pixel_ack=0 for 5 cycles while output is valid -> o_pixel_ack=0, outputs constant; after release, the sequence is unchanged and complete.
REQ-034 i_sof asserted at column 2 of row 3 -> no output for the next 8 accepted pixels; output then resumes with top = first post-sof row.
REQ-035 Random i_pixel_valid/i_pixel_ack gaps over 6 rows -> output stream equals the golden model and the count equals 4*(rows-2).
